// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: in-order fetch-to-decode instruction buffer that stamps each issued entry with a major ID
module fetch_issue_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 8
) (
  input  logic                               clock_i,
  input  logic                               resetn_i,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  input  logic [instructionWidth-1:0]        fetchInstruction_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  output logic                               fetchReady_o,
  input  logic                               stall_i,
  output logic                               outputEnable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o,
  output logic [$clog2(queueDepth):0]        count_o
);
  localparam int PW = $clog2(queueDepth);
  localparam int CW = PW + 1;
  localparam int MW = instructionCounterWidth;
  logic [instructionWidth-1:0] ins_q [queueDepth];
  logic [addressWidth-1:0]     adr_q [queueDepth];
  logic [PidSize-1:0]          pid_q [queueDepth];
  logic [TidSize-1:0]          tid_q [queueDepth];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] maj_q, maj_d;
  logic push, pop;
  always_comb begin
    fetchReady_o   = cnt_q != CW'(queueDepth);
    outputEnable_o = cnt_q != '0;
    push  = fetchValid_i && fetchReady_o && !flush_i;
    pop   = outputEnable_o && !stall_i && !flush_i;
    rd_d  = flush_i ? '0 : rd_q + PW'(pop);
    wr_d  = flush_i ? '0 : wr_q + PW'(push);
    cnt_d = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    // the issue counter survives flushes so IDs stay unique
    maj_d = maj_q + MW'(pop);
  end
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      maj_q <= '0;
      for (int k = 0; k < queueDepth; k++) begin
        ins_q[k] <= '0;
        adr_q[k] <= '0;
        pid_q[k] <= '0;
        tid_q[k] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      maj_q <= maj_d;
      if (push) begin
        ins_q[wr_q] <= fetchInstruction_i;
        adr_q[wr_q] <= fetchAddress_i;
        pid_q[wr_q] <= fetchPid_i;
        tid_q[wr_q] <= fetchTid_i;
      end
    end
  end
  assign instruction_o        = ins_q[rd_q];
  assign instructionAddress_o = adr_q[rd_q];
  assign instructionPid_o     = pid_q[rd_q];
  assign instructionTid_o     = tid_q[rd_q];
  assign instructionMajId_o   = maj_q;
  assign count_o              = cnt_q;
endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb_fetch_issue_queue: directed scoreboard bench; a second instance with a 4-bit major ID shares all inputs
module tb_fetch_issue_queue;
  logic clk = 0, rstn = 0, flush = 0, valid = 0, stall = 0;
  logic [31:0] ins = 0;
  logic [63:0] addr = 0;
  logic [19:0] pid = 0;
  logic [15:0] tid = 0;
  logic ready, oe, b_ready, b_oe;
  logic [31:0] o_ins, b_ins;
  logic [63:0] o_addr, b_addr, o_maj;
  logic [19:0] o_pid, b_pid;
  logic [15:0] o_tid, b_tid;
  logic [3:0] cnt, b_cnt, b_maj;
  typedef struct packed {logic [31:0] i; logic [63:0] a; logic [19:0] p; logic [15:0] t;} ent_t;
  ent_t sb[$];
  logic [63:0] mj = 0;
  int n_chk = 0, n_fail = 0, n_rdy = 0;
  logic acc;

  fetch_issue_queue dut (
    .clock_i(clk), .resetn_i(rstn), .flush_i(flush), .fetchValid_i(valid),
    .fetchInstruction_i(ins), .fetchAddress_i(addr), .fetchPid_i(pid), .fetchTid_i(tid),
    .fetchReady_o(ready), .stall_i(stall), .outputEnable_o(oe), .instruction_o(o_ins),
    .instructionAddress_o(o_addr), .instructionPid_o(o_pid), .instructionTid_o(o_tid),
    .instructionMajId_o(o_maj), .count_o(cnt));

  fetch_issue_queue #(.instructionCounterWidth(4)) dut_b (
    .clock_i(clk), .resetn_i(rstn), .flush_i(flush), .fetchValid_i(valid),
    .fetchInstruction_i(ins), .fetchAddress_i(addr), .fetchPid_i(pid), .fetchTid_i(tid),
    .fetchReady_o(b_ready), .stall_i(stall), .outputEnable_o(b_oe), .instruction_o(b_ins),
    .instructionAddress_o(b_addr), .instructionPid_o(b_pid), .instructionTid_o(b_tid),
    .instructionMajId_o(b_maj), .count_o(b_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_idle_reset();
    chk("rst_oe", 64'(oe), 0);
    chk("rst_ready", 64'(ready), 1);
    chk("rst_count", 64'(cnt), 0);
    chk("rst_ins", 64'(o_ins), 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_pid", 64'(o_pid), 0);
    chk("rst_tid", 64'(o_tid), 0);
    chk("rst_maj", o_maj, 0);
    chk("rst_bmaj", 64'(b_maj), 0);
  endtask

  // one cycle: drive inputs, check registered outputs against the model, then advance the model
  task automatic step(input logic v, input logic s, input logic f, input logic [31:0] i, input logic [63:0] a);
    ent_t e;
    logic pop;
    valid = v; stall = s; flush = f; ins = i; addr = a;
    pid = i[19:0] ^ 20'hA5A5A;
    tid = a[15:0] ^ 16'h3C3C;
    chk("count", 64'(cnt), 64'(sb.size()));
    chk("ready", 64'(ready), 64'(sb.size() != 8));
    chk("oe", 64'(oe), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_ins", 64'(o_ins), 64'(sb[0].i));
      chk("head_addr", o_addr, sb[0].a);
      chk("head_pid", 64'(o_pid), 64'(sb[0].p));
      chk("head_tid", 64'(o_tid), 64'(sb[0].t));
      chk("head_maj", o_maj, mj);
      chk("head_bmaj", 64'(b_maj), 64'(mj[3:0]));
    end
    if (v && ready) n_rdy++;
    acc = v && sb.size() != 8 && !f;
    pop = sb.size() != 0 && !s && !f;
    e = '{i: i, a: a, p: pid, t: tid};
    @(posedge clk);
    if (f) sb.delete();
    else begin
      if (pop) begin
        void'(sb.pop_front());
        mj++;
      end
      if (acc) sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rstn = 0;
    #1 chk_idle_reset();
    sb.delete();
    mj = 0;
    @(negedge clk) rstn = 1;
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h48000010; prog[1] = 32'h7C0802A6; prog[2] = 32'h38210010;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk_idle_reset();
    // streaming
    for (int k = 0; k < 3; k++) step(1, 0, 0, prog[k], 64'h1000 + 64'(4 * k));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // backpressure: 10 offered, 8 accepted
    n_rdy = 0;
    for (int k = 0; k < 10; k++) step(1, 1, 0, 32'hA000_0000 + 32'(k), 64'h2000 + 64'(4 * k));
    chk("bp_accepted", 64'(n_rdy), 8);
    chk("bp_full_ready", 64'(ready), 0);
    chk("bp_full_count", 64'(cnt), 8);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0);
    // concurrent push/pop at occupancy 3
    for (int k = 0; k < 3; k++) step(1, 1, 0, 32'hB000_0000 + 32'(k), 64'h3000 + 64'(4 * k));
    for (int k = 3; k < 23; k++) step(1, 0, 0, 32'hB000_0000 + 32'(k), 64'h3000 + 64'(4 * k));
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    // asynchronous reset mid-burst at count 5
    for (int k = 0; k < 5; k++) step(1, 1, 0, 32'hC000_0000 + 32'(k), 64'h4000 + 64'(4 * k));
    chk("mid_count", 64'(cnt), 5);
    async_reset();
    // flush at count 4 after majId 5 issued
    for (int k = 0; k < 6; k++) step(1, 0, 0, 32'hD000_0000 + 32'(k), 64'h5000 + 64'(4 * k));
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 32'hE000_0000 + 32'(k), 64'h6000 + 64'(4 * k));
    step(1, 0, 1, 32'hEEEE_EEEE, 64'h6FFC);
    chk("flush_count", 64'(cnt), 0);
    chk("flush_oe", 64'(oe), 0);
    step(1, 0, 0, 32'hF000_0000, 64'h7000);
    chk("flush_next_maj", o_maj, 6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 4-bit major-ID wrap over 17 issues
    async_reset();
    for (int k = 0; k < 17; k++) step(1, 0, 0, 32'h1234_0000 + 32'(k), 64'h8000 + 64'(4 * k));
    step(0, 0, 0, 0, 0);
    chk("wrap_bmaj", 64'(b_maj), 1);
    chk("wrap_maj", o_maj, 17);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
